// File: rtl/aclk_counter.sv
// aclk_counter: 24-hour BCD current/alarm time registers
// Advances on one_minute; loads validated key digits.
module aclk_counter #(
  parameter int RST_HR  = 0,
  parameter int RST_MIN = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic       load_new_a,
  input  logic [3:0] key_ms_hr,
  input  logic [3:0] key_ls_hr,
  input  logic [3:0] key_ms_min,
  input  logic [3:0] key_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic [3:0] alarm_time_ms_hr,
  output logic [3:0] alarm_time_ls_hr,
  output logic [3:0] alarm_time_ms_min,
  output logic [3:0] alarm_time_ls_min,
  output logic       load_err
);

  typedef struct packed {
    logic [3:0] mh;
    logic [3:0] lh;
    logic [3:0] mm;
    logic [3:0] lm;
  } hhmm_t;

  localparam logic [3:0] RMH = 4'(RST_HR / 10);
  localparam logic [3:0] RLH = 4'(RST_HR % 10);
  localparam logic [3:0] RMM = 4'(RST_MIN / 10);
  localparam logic [3:0] RLM = 4'(RST_MIN % 10);

  hhmm_t key_t;
  hhmm_t cur_q;
  hhmm_t cur_d;
  hhmm_t alm_q;
  logic  key_ok;

  assign key_t = '{mh: key_ms_hr,  lh: key_ls_hr,
                   mm: key_ms_min, lm: key_ls_min};

  // Key digits must form a legal 24-hour HH:MM
  always_comb begin
    key_ok = 1'b1;
    if (key_ms_hr > 4'd2)  key_ok = 1'b0;
    if (key_ls_hr > 4'd9)  key_ok = 1'b0;
    if (key_ms_hr == 4'd2 && key_ls_hr > 4'd3)
      key_ok = 1'b0;
    if (key_ms_min > 4'd5) key_ok = 1'b0;
    if (key_ls_min > 4'd9) key_ok = 1'b0;
  end

  // Current-time next state: load beats tick; 23:59 wraps directly
  always_comb begin
    cur_d = cur_q;
    if (load_new_c) begin
      if (key_ok) cur_d = key_t;
    end else if (one_minute) begin
      if (cur_q.lm != 4'd9) begin
        cur_d.lm = cur_q.lm + 4'd1;
      end else begin
        cur_d.lm = 4'd0;
        if (cur_q.mm != 4'd5) begin
          cur_d.mm = cur_q.mm + 4'd1;
        end else begin
          cur_d.mm = 4'd0;
          if (cur_q.mh == 4'd2 && cur_q.lh == 4'd3) begin
            cur_d.mh = 4'd0;
            cur_d.lh = 4'd0;
          end else if (cur_q.lh == 4'd9) begin
            cur_d.lh = 4'd0;
            cur_d.mh = cur_q.mh + 4'd1;
          end else begin
            cur_d.lh = cur_q.lh + 4'd1;
          end
        end
      end
    end
  end

  // State registers; reset discards any same-cycle load or tick
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q    <= '{mh: RMH, lh: RLH, mm: RMM, lm: RLM};
      alm_q    <= '0;
      load_err <= 1'b0;
    end else begin
      cur_q <= cur_d;
      if (load_new_a && key_ok) alm_q <= key_t;
      load_err <= (load_new_c | load_new_a) & ~key_ok;
    end
  end

  assign current_time_ms_hr  = cur_q.mh;
  assign current_time_ls_hr  = cur_q.lh;
  assign current_time_ms_min = cur_q.mm;
  assign current_time_ls_min = cur_q.lm;
  assign alarm_time_ms_hr    = alm_q.mh;
  assign alarm_time_ls_hr    = alm_q.lh;
  assign alarm_time_ms_min   = alm_q.mm;
  assign alarm_time_ls_min   = alm_q.lm;

endmodule

// File: tb/tb_aclk_counter.sv
// tb_aclk_counter: scoreboard bench for aclk_counter
// Model keeps time as minutes-of-day integers.
module tb_aclk_counter;

  logic clock = 1'b0;
  logic reset, one_minute, load_new_c, load_new_a;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic [3:0] a_mh, a_lh, a_mm, a_lm;
  logic load_err;

  always #5 clock = ~clock;

  aclk_counter #(.RST_HR(0), .RST_MIN(0)) dut (
    .clock(clock), .reset(reset),
    .one_minute(one_minute),
    .load_new_c(load_new_c), .load_new_a(load_new_a),
    .key_ms_hr(key_ms_hr), .key_ls_hr(key_ls_hr),
    .key_ms_min(key_ms_min), .key_ls_min(key_ls_min),
    .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
    .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
    .alarm_time_ms_hr(a_mh), .alarm_time_ls_hr(a_lh),
    .alarm_time_ms_min(a_mm), .alarm_time_ls_min(a_lm),
    .load_err(load_err)
  );

  typedef struct {
    int cur;
    int alm;
    bit err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int m_cur = 0;
  int m_alm = 0;
  bit done = 0;

  function automatic logic [15:0] bcd(input int m);
    int h, mi;
    h  = m / 60;
    mi = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  task automatic step(input bit rst, input bit lc,
                      input bit la, input bit om,
                      input int d0, input int d1,
                      input int d2, input int d3);
    int hr, mi;
    bit ok;
    exp_t e;
    @(negedge clock);
    reset = rst; load_new_c = lc; load_new_a = la;
    one_minute = om;
    key_ms_hr = 4'(d0); key_ls_hr = 4'(d1);
    key_ms_min = 4'(d2); key_ls_min = 4'(d3);
    hr = d0 * 10 + d1;
    mi = d2 * 10 + d3;
    ok = (d0 <= 2) && (d1 <= 9) && (hr < 24) &&
         (d2 <= 5) && (d3 <= 9);
    e.err = 0;
    if (rst) begin
      m_cur = 0;
      m_alm = 0;
    end else begin
      if (lc) begin
        if (ok) m_cur = hr * 60 + mi;
      end else if (om) begin
        m_cur = (m_cur + 1) % 1440;
      end
      if (la && ok) m_alm = hr * 60 + mi;
      e.err = (lc || la) && !ok;
    end
    e.cur = m_cur;
    e.alm = m_alm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ldc(input int a, input int b,
                     input int c, input int d);
    step(0, 1, 0, 0, a, b, c, d);
  endtask

  task automatic tick();
    step(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle after an edge
  initial begin
    exp_t e;
    logic [15:0] cv, av;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        cv = {c_mh, c_lh, c_mm, c_lm};
        av = {a_mh, a_lh, a_mm, a_lm};
        checks++;
        if (cv !== bcd(e.cur)) begin
          failures++;
          $display("FAIL current got=%h want=%h t=%0t",
                   cv, bcd(e.cur), $time);
        end
        checks++;
        if (av !== bcd(e.alm)) begin
          failures++;
          $display("FAIL alarm got=%h want=%h t=%0t",
                   av, bcd(e.alm), $time);
        end
        checks++;
        if (load_err !== e.err) begin
          failures++;
          $display("FAIL load_err got=%b want=%b t=%0t",
                   load_err, e.err, $time);
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1; one_minute = 0;
    load_new_c = 0; load_new_a = 0;
    key_ms_hr = 0; key_ls_hr = 0;
    key_ms_min = 0; key_ls_min = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    ldc(0, 9, 4, 5);
    tick(); tick(); tick();
    idle(1);
    ldc(2, 3, 5, 9); tick();
    ldc(0, 9, 5, 9); tick();
    ldc(1, 9, 5, 9); tick();
    step(0, 0, 1, 0, 1, 5, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 2, 4, 0, 0);
    idle(2);
    step(0, 1, 0, 1, 1, 0, 3, 0);
    ldc(0, 6, 7, 0);
    idle(1);
    ldc(1, 2, 3, 4);
    step(1, 1, 0, 1, 0, 8, 0, 0);
    idle(2);
    step(0, 1, 1, 1, 2, 3, 5, 9);
    step(0, 1, 1, 1, 2, 4, 0, 0);
    step(0, 0, 1, 1, 9, 9, 9, 9);
    for (int i = 0; i < 1500; i++) tick();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 2, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) != 0,
           (r < 80) ? $urandom_range(0, 2)
                    : $urandom_range(0, 15),
           (r < 80) ? $urandom_range(0, 9)
                    : $urandom_range(0, 15),
           (r < 80) ? $urandom_range(0, 5)
                    : $urandom_range(0, 15),
           $urandom_range(0, (r < 90) ? 9 : 15));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
